// File: rtl/mem_page_pkg.sv
// Shared types and helpers for the paged memory writer and reader.
// - state_e : writer FSM states
// - page_of : maps a BX value onto a page index
// - ADDR_W / PAGE_W / NENT_W : widths for the default 16-deep, 2-page configuration
package mem_page_pkg;

  localparam int unsigned DEF_RAM_DEPTH = 16;
  localparam int unsigned DEF_PAGES     = 2;

  localparam int unsigned ADDR_W = $clog2(DEF_RAM_DEPTH);
  localparam int unsigned PAGE_W = (DEF_PAGES > 1) ? $clog2(DEF_PAGES) : 1;
  localparam int unsigned NENT_W = $clog2(DEF_RAM_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone,
    StFull
  } state_e;

  function automatic int unsigned page_of(input int unsigned bx, input int unsigned pages);
    return bx % pages;
  endfunction

endpackage

// File: rtl/mem_page_bx_edge_det.sv
// BX change detector, shared by the writer and reader sides.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   en_i         : enable; no change is reported while low
//   active_i     : owner is tracking a page; no change is reported while low
//   bx_i         : current BX
//   bx_q_o       : BX registered every cycle
//   bx_change_o  : bx_i differs from the previous cycle's BX
module bx_edge_det #(
  parameter int unsigned BX_WIDTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                active_i,
  input  logic [BX_WIDTH-1:0] bx_i,
  output logic [BX_WIDTH-1:0] bx_q_o,
  output logic                bx_change_o
);

  logic [BX_WIDTH-1:0] bx_q, bx_d;

  // bx_q follows bx_in even while disabled, so a change seen only during en = 0 is dropped.
  always_comb begin
    bx_d = bx_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q <= '0;
    end else begin
      bx_q <= bx_d;
    end
  end

  assign bx_q_o      = bx_q;
  assign bx_change_o = en_i && active_i && (bx_i != bx_q);

endmodule

// File: rtl/mem_page_writer.sv
// Writes a valid/ready word stream into the memory page chosen by the current BX and
// publishes a per-page entry count for the downstream reader.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   en                               : enable for BX tracking and writing
//   bx_in                            : current BX; a change closes the page and opens the next
//   s_valid/s_data/s_last/s_ready    : input word stream
//   mem_wea/mem_addra/mem_dina/mem_pagea : registered port-A write side of the memory
//   nent_o                           : entry count per page, page p at [p*NENT_W +: NENT_W]
//   bx_out / bx_done                 : BX of the last closed page, one-cycle close pulse
//   overflow                         : word offered while the page was full
module mem_page_writer #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH = 16,
  parameter int unsigned PAGES     = 2,
  parameter int unsigned BX_WIDTH  = 2,
  localparam int unsigned AddrW = $clog2(RAM_DEPTH),
  localparam int unsigned PageW = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int unsigned NentW = $clog2(RAM_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [BX_WIDTH-1:0]      bx_in,
  input  logic                     s_valid,
  input  logic [RAM_WIDTH-1:0]     s_data,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic                     mem_wea,
  output logic [AddrW-1:0]         mem_addra,
  output logic [RAM_WIDTH-1:0]     mem_dina,
  output logic [PageW-1:0]         mem_pagea,
  output logic [PAGES*NentW-1:0]   nent_o,
  output logic [BX_WIDTH-1:0]      bx_out,
  output logic                     bx_done,
  output logic                     overflow
);

  import mem_page_pkg::*;

  state_e                      state_q, state_d;
  logic [NentW-1:0]            cnt_q, cnt_d;
  logic [PageW-1:0]            page_q, page_d;
  logic [PAGES-1:0][NentW-1:0] nent_q, nent_d;
  logic [BX_WIDTH-1:0]         bx_out_q, bx_out_d;
  logic                        bx_done_q, bx_done_d;
  logic                        overflow_q, overflow_d;
  logic                        wea_q, wea_d;
  logic [AddrW-1:0]            addr_q, addr_d;
  logic [RAM_WIDTH-1:0]        din_q, din_d;

  logic [BX_WIDTH-1:0]         bx_q;
  logic                        bx_change;
  logic [PageW-1:0]            new_page;

  bx_edge_det #(
    .BX_WIDTH(BX_WIDTH)
  ) u_bx_edge_det (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .active_i   (state_q != StIdle),
    .bx_i       (bx_in),
    .bx_q_o     (bx_q),
    .bx_change_o(bx_change)
  );

  assign new_page = PageW'(page_of(32'(bx_in), PAGES));

  // A BX change blocks the handshake so no word can land in the page being closed.
  assign s_ready = en && (state_q == StWrite) && !bx_change;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_d     = page_q;
    nent_d     = nent_q;
    bx_out_d   = bx_out_q;
    bx_done_d  = 1'b0;
    overflow_d = overflow_q;
    wea_d      = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;

    if (en) begin
      if (state_q == StIdle || bx_change) begin
        if (bx_change) begin
          nent_d[page_q] = cnt_q;
          bx_out_d       = bx_q;
          bx_done_d      = 1'b1;
        end
        // Open the page for the new BX; its stale count is cleared after any close above.
        page_d           = new_page;
        nent_d[new_page] = '0;
        overflow_d       = 1'b0;
        cnt_d            = '0;
        state_d          = StWrite;
      end else begin
        case (state_q)
          StWrite: begin
            if (s_valid) begin
              wea_d  = 1'b1;
              addr_d = cnt_q[AddrW-1:0];
              din_d  = s_data;
              if (cnt_q != NentW'(RAM_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
              end
              if (s_last) begin
                state_d = StDone;
              end else if (cnt_q == NentW'(RAM_DEPTH - 1)) begin
                state_d = StFull;
              end
            end
          end
          StFull: begin
            if (s_valid) begin
              overflow_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      page_q     <= '0;
      nent_q     <= '0;
      bx_out_q   <= '0;
      bx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      wea_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      nent_q     <= nent_d;
      bx_out_q   <= bx_out_d;
      bx_done_q  <= bx_done_d;
      overflow_q <= overflow_d;
      wea_q      <= wea_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  // page_q only moves at a close edge, after the last write of the old page has been shown.
  assign mem_wea   = wea_q;
  assign mem_addra = addr_q;
  assign mem_dina  = din_q;
  assign mem_pagea = page_q;
  assign nent_o    = nent_q;
  assign bx_out    = bx_out_q;
  assign bx_done   = bx_done_q;
  assign overflow  = overflow_q;

endmodule
